// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB3 GPIO subsystem.
//   - apb_state_e : master FSM states
//   - REG_*       : GPIO register word indices
//   - NREGS       : number of implemented registers
//   - strb_merge  : byte-lane merge of write data under PSTRB
package apb_gpio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int NREGS = 8;

   localparam logic [2:0] REG_MODE  = 3'd0;
   localparam logic [2:0] REG_DIR   = 3'd1;
   localparam logic [2:0] REG_ODATA = 3'd2;
   localparam logic [2:0] REG_IDATA = 3'd3;
   localparam logic [2:0] REG_ITYPE = 3'd4;
   localparam logic [2:0] REG_IEN   = 3'd5;
   localparam logic [2:0] REG_IPOL  = 3'd6;
   localparam logic [2:0] REG_ISTAT = 3'd7;

   // Expand the 4 strobes into a 32-bit lane mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

   // Replace only the strobed bytes of cur with wdata.
   function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
      logic [31:0] m;
      m = strb_mask(strb);
      return (cur & ~m) | (wdata & m);
   endfunction

endpackage

// File: rtl/apb_gpio_slave.sv
// Zero-wait-state APB3 GPIO slave.
// Ports:
//   PCLK, PRESETn        clock, synchronous active-low reset
//   PSEL, PENABLE        APB phase qualifiers from the master
//   PWRITE, PADDR        direction and 33-bit word address ([32] must be 0)
//   PWDATA, PSTRB        write data and byte-lane strobes
//   PRDATA, PREADY       read data (0 on error), ready (always 1)
//   PSLVERR              error during ACCESS for out-of-range address
//   gpioIO               bidirectional pins
module apb_gpio_slave
   import apb_gpio_pkg::*;
#(
   parameter int NGPIO = 32
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             PSEL,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [32:0]      PADDR,
   input  logic [31:0]      PWDATA,
   input  logic [3:0]       PSTRB,
   output logic [31:0]      PRDATA,
   output logic             PREADY,
   output logic             PSLVERR,
   inout  wire  [NGPIO-1:0] gpioIO
);

   logic [NGPIO-1:0] mode_q, dir_q, odata_q, idata_q, itype_q, ien_q, ipol_q, istat_q;
   logic [NGPIO-1:0] prev_q;

   logic             addr_err;
   logic [2:0]       idx;
   logic             wr_en;
   logic [NGPIO-1:0] istat_clr;
   logic [NGPIO-1:0] edge_hit, lvl_hit, istat_set;

   // Index >7 or the reserved top bit both count as an invalid address.
   assign addr_err = PADDR[32] | (|PADDR[31:3]);
   assign idx      = PADDR[2:0];
   assign PREADY   = 1'b1;
   assign PSLVERR  = PSEL & PENABLE & addr_err;
   assign wr_en    = PSEL & PENABLE & PWRITE & ~addr_err;

   assign istat_clr = (wr_en && idx == REG_ISTAT) ? (PWDATA & strb_mask(PSTRB)) : '0;

   // Polarity match: IPOL=1 wants a high/rising pin, IPOL=0 low/falling.
   assign lvl_hit   = ~(idata_q ^ ipol_q);
   assign edge_hit  = (prev_q ^ idata_q) & lvl_hit;
   assign istat_set = ien_q & ((itype_q & edge_hit) | (~itype_q & lvl_hit));

   always_comb begin
      PRDATA = '0;
      if (!addr_err) begin
         case (idx)
            REG_MODE:  PRDATA = mode_q;
            REG_DIR:   PRDATA = dir_q;
            REG_ODATA: PRDATA = odata_q;
            REG_IDATA: PRDATA = idata_q;
            REG_ITYPE: PRDATA = itype_q;
            REG_IEN:   PRDATA = ien_q;
            REG_IPOL:  PRDATA = ipol_q;
            REG_ISTAT: PRDATA = istat_q;
            default:   PRDATA = '0;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         mode_q  <= '0;
         dir_q   <= '0;
         odata_q <= '0;
         idata_q <= '0;
         itype_q <= '0;
         ien_q   <= '0;
         ipol_q  <= '0;
         istat_q <= '0;
         prev_q  <= '0;
      end else begin
         idata_q <= gpioIO;
         prev_q  <= idata_q;
         // A new interrupt event must not be lost to a simultaneous clear.
         istat_q <= (istat_q & ~istat_clr) | istat_set;
         if (wr_en) begin
            case (idx)
               REG_MODE:  mode_q  <= strb_merge(mode_q,  PWDATA, PSTRB);
               REG_DIR:   dir_q   <= strb_merge(dir_q,   PWDATA, PSTRB);
               REG_ODATA: odata_q <= strb_merge(odata_q, PWDATA, PSTRB);
               REG_ITYPE: itype_q <= strb_merge(itype_q, PWDATA, PSTRB);
               REG_IEN:   ien_q   <= strb_merge(ien_q,   PWDATA, PSTRB);
               REG_IPOL:  ipol_q  <= strb_merge(ipol_q,  PWDATA, PSTRB);
               default: ;
            endcase
         end
      end
   end

   // Open-drain pins only ever pull low; a 1 releases the line.
   for (genvar i = 0; i < NGPIO; i++) begin : g_pad
      assign gpioIO[i] = !dir_q[i] ? 1'bz :
                         mode_q[i] ? (odata_q[i] ? 1'bz : 1'b0) :
                                     odata_q[i];
   end

endmodule

// File: rtl/apb_protocol.sv
// APB3 subsystem top: master FSM driven by a user request interface,
// connected to one GPIO slave.
// Ports:
//   PCLK, PRESETn      clock, synchronous active-low reset
//   transfer           keep issuing APB transfers while high
//   READ_WRITE         0 = write, 1 = read
//   apb_write_paddr    write word address ([32] must be 0)
//   apb_read_paddr     read word address (same encoding)
//   apb_write_data     write data
//   PSTRB              byte-lane write strobes
//   PSLVERR            slave error of the current access
//   apb_read_data_out  {err, PRDATA} captured when a read ACCESS completes
//   gpioIO             GPIO pins
module apb_protocol
   import apb_gpio_pkg::*;
#(
   parameter int NGPIO = 32
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             transfer,
   input  logic             READ_WRITE,
   input  logic [32:0]      apb_write_paddr,
   input  logic [32:0]      apb_read_paddr,
   input  logic [31:0]      apb_write_data,
   input  logic [3:0]       PSTRB,
   output logic             PSLVERR,
   output logic [32:0]      apb_read_data_out,
   inout  wire  [NGPIO-1:0] gpioIO
);

   apb_state_e  state_q, state_d;
   logic        psel, penable, pwrite, pready;
   logic [32:0] paddr;
   logic [31:0] prdata;

   // Address and direction follow the user inputs with no registering.
   assign pwrite = ~READ_WRITE;
   assign paddr  = READ_WRITE ? apb_read_paddr : apb_write_paddr;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      psel    = 1'b0;
      penable = 1'b0;
      case (state_q)
         IDLE: begin
            if (transfer) state_d = SETUP;
         end
         SETUP: begin
            psel    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) state_d = transfer ? SETUP : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         apb_read_data_out <= '0;
      end else if (state_q == ACCESS && pready && !pwrite) begin
         apb_read_data_out <= {PSLVERR, prdata};
      end
   end

   apb_gpio_slave #(
      .NGPIO (NGPIO)
   ) u_gpio (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .PSEL    (psel),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (apb_write_data),
      .PSTRB   (PSTRB),
      .PRDATA  (prdata),
      .PREADY  (pready),
      .PSLVERR (PSLVERR),
      .gpioIO  (gpioIO)
   );

endmodule

// File: tb/tb_apb_protocol.sv
module tb_apb_protocol;

   logic        PCLK = 1'b0;
   logic        PRESETn, transfer, READ_WRITE;
   logic [32:0] wpa, rpa;
   logic [31:0] wdata;
   logic [3:0]  PSTRB;
   wire         PSLVERR;
   wire  [32:0] rdo;
   wire  [31:0] gpio;
   logic [31:0] tb_oe, tb_val;

   int total = 0;
   int bad   = 0;

   // Reference register image, indexed by word address.
   logic [31:0] m [0:7];

   always #5 PCLK = ~PCLK;

   for (genvar g = 0; g < 32; g++) begin : g_drv
      assign gpio[g] = tb_oe[g] ? tb_val[g] : 1'bz;
   end

   apb_protocol dut (
      .PCLK              (PCLK),
      .PRESETn           (PRESETn),
      .transfer          (transfer),
      .READ_WRITE        (READ_WRITE),
      .apb_write_paddr   (wpa),
      .apb_read_paddr    (rpa),
      .apb_write_data    (wdata),
      .PSTRB             (PSTRB),
      .PSLVERR           (PSLVERR),
      .apb_read_data_out (rdo),
      .gpioIO            (gpio)
   );

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   // Pins the DUT actively drives: outputs, except open-drain ones holding 1.
   function automatic logic [31:0] dut_drives();
      return m[1] & ~(m[0] & m[2]);
   endfunction

   // Resolved pin value: DUT drive where it drives, bench drive elsewhere.
   function automatic logic [31:0] pins_exp();
      logic [31:0] d;
      d = dut_drives();
      return (d & m[2] & ~m[0]) | (~d & tb_val);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m[i] = '0;
   endtask

   task automatic model_write(input logic [32:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] lm;
      lm = lane_mask(s);
      if (a[32] || a[31:0] > 7) return;
      if (a[2:0] == 3'd3) return;
      if (a[2:0] == 3'd7) m[7] = m[7] & ~(d & lm);
      else m[a[2:0]] = (m[a[2:0]] & ~lm) | (d & lm);
   endtask

   function automatic logic [32:0] model_read(input logic [32:0] a);
      if (a[32] || a[31:0] > 7) return {1'b1, 32'h0};
      if (a[2:0] == 3'd3) return {1'b0, pins_exp()};
      return {1'b0, m[a[2:0]]};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESETn  = 1'b0;
      transfer = 1'b0;
      idle(2);
      PRESETn = 1'b1;
      model_reset();
   endtask

   // One complete transfer; returns PSLVERR seen in ACCESS and read data after it.
   task automatic xfer(input logic rw, input logic [32:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic err_acc, output logic [32:0] rd);
      @(negedge PCLK);
      transfer   = 1'b1;
      READ_WRITE = rw;
      if (rw) begin
         rpa = a;
         wpa = {1'b0, $urandom};
      end else begin
         wpa = a;
         rpa = {1'b0, $urandom};
      end
      wdata = d;
      PSTRB = s;
      @(negedge PCLK);
      @(negedge PCLK);
      err_acc  = PSLVERR;
      transfer = 1'b0;
      @(negedge PCLK);
      rd = rdo;
      if (!rw) model_write(a, d, s);
   endtask

   task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] s);
      logic        e;
      logic [32:0] r;
      xfer(1'b0, 33'(idx), d, s, e, r);
   endtask

   logic        e;
   logic [32:0] r, ra, exp_r;
   logic        exp_e, rw;
   int          idx;
   logic [31:0] rd_d;
   logic [3:0]  rs;

   initial begin
      PRESETn = 1'b0; transfer = 1'b0; READ_WRITE = 1'b0;
      wpa = '0; rpa = '0; wdata = '0; PSTRB = 4'hF;
      tb_oe = '0; tb_val = '0;
      model_reset();

      do_reset();
      chk("reset_rdata", rdo, 33'h0);
      chk("reset_slverr", {32'h0, PSLVERR}, 33'h0);

      // Push-pull outputs.
      wr(1, 32'hFFFFFFFF, 4'hF);
      wr(2, 32'h0000001F, 4'hF);
      wr(0, 32'h00000000, 4'hF);
      idle(1);
      chk("pushpull_pins", {1'b0, gpio}, 33'h00000001F);

      // Open drain: low five pins released, bench pulls them high.
      wr(0, 32'hFFFFFFFF, 4'hF);
      tb_oe = 32'h0000001F; tb_val = 32'hFFFFFFFF;
      idle(2);
      chk("opendrain_pins", {1'b0, gpio}, 33'h00000001F);
      xfer(1'b1, 33'd3, 32'h0, 4'hF, e, r);
      chk("opendrain_idata", r, 33'h00000001F);

      // Inputs.
      tb_oe = '0;
      wr(1, 32'h0, 4'hF);
      tb_oe = 32'hFFFFFFFF; tb_val = 32'h5;
      idle(2);
      xfer(1'b1, 33'd3, 32'h0, 4'hF, e, r);
      chk("idata_read", r, 33'h000000005);
      chk("idata_noerr", {32'h0, e}, 33'h0);

      // Edge interrupt on pin 0 rising.
      tb_val = 32'h0;
      idle(2);
      wr(4, 32'hFFFFFFFF, 4'hF);
      wr(6, 32'hFFFFFFFF, 4'hF);
      wr(5, 32'hFFFFFFFF, 4'hF);
      idle(2);
      xfer(1'b1, 33'd7, 32'h0, 4'hF, e, r);
      chk("istat_quiet", r, 33'h0);
      tb_val = 32'h1;
      idle(3);
      xfer(1'b1, 33'd7, 32'h0, 4'hF, e, r);
      chk("istat_edge", r, 33'h000000001);
      wr(7, 32'h1, 4'hF);
      xfer(1'b1, 33'd7, 32'h0, 4'hF, e, r);
      chk("istat_w1c", r, 33'h0);

      // Level mode: a high pin keeps re-setting its bit despite clears.
      wr(4, 32'h0, 4'hF);
      wr(7, 32'hFFFFFFFF, 4'hF);
      xfer(1'b1, 33'd7, 32'h0, 4'hF, e, r);
      chk("istat_level", r, 33'h000000001);
      wr(5, 32'h0, 4'hF);
      wr(7, 32'hFFFFFFFF, 4'hF);
      xfer(1'b1, 33'd7, 32'h0, 4'hF, e, r);
      chk("istat_disabled", r, 33'h0);

      // Byte strobes.
      wr(2, 32'h0, 4'hF);
      wr(2, 32'hFFFFFFFF, 4'b0001);
      xfer(1'b1, 33'd2, 32'h0, 4'hF, e, r);
      chk("strb_byte0", r, 33'h0000000FF);
      wr(2, 32'h12345678, 4'b1010);
      xfer(1'b1, 33'd2, 32'h0, 4'hF, e, r);
      chk("strb_bytes13", r, 33'h0120056FF);

      // Errors.
      xfer(1'b1, 33'd9, 32'h0, 4'hF, e, r);
      chk("err_rd_slverr", {32'h0, e}, 33'h1);
      chk("err_rd_data", r, 33'h100000000);
      xfer(1'b0, {1'b1, 32'd2}, 32'h0, 4'hF, e, r);
      chk("err_wr_slverr", {32'h0, e}, 33'h1);
      xfer(1'b1, 33'd2, 32'h0, 4'hF, e, r);
      chk("err_wr_nochange", r, 33'h0120056FF);
      wr(3, 32'hFFFFFFFF, 4'hF);
      xfer(1'b1, 33'd3, 32'h0, 4'hF, e, r);
      chk("idata_ro", r, 33'h000000001);

      // Reset in the middle of an ACCESS write.
      @(negedge PCLK);
      transfer = 1'b1; READ_WRITE = 1'b0; wpa = 33'd2; wdata = 32'hAAAAAAAA; PSTRB = 4'hF;
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn  = 1'b0;
      transfer = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      model_reset();
      chk("midreset_rdata", rdo, 33'h0);
      chk("midreset_slverr", {32'h0, PSLVERR}, 33'h0);
      xfer(1'b1, 33'd2, 32'h0, 4'hF, e, r);
      chk("midreset_odata", r, 33'h0);
      xfer(1'b1, 33'd1, 32'h0, 4'hF, e, r);
      chk("midreset_dir", r, 33'h0);

      // Randomised traffic against the register model.
      do_reset();
      tb_val = $urandom;
      tb_oe  = ~dut_drives();
      idle(2);
      for (int k = 0; k < 60; k++) begin
         rw   = 1'($urandom_range(0, 1));
         idx  = $urandom_range(0, 9);
         ra   = 33'(idx);
         if ($urandom_range(0, 7) == 0) ra[32] = 1'b1;
         rd_d = $urandom;
         rs   = 4'($urandom);
         // Keep interrupts disabled so status stays predictable.
         if (idx == 5) rd_d = 32'h0;
         exp_e = ra[32] || (idx > 7);
         exp_r = rw ? model_read(ra) : rdo;
         xfer(rw, ra, rd_d, rs, e, r);
         chk("rand_slverr", {32'h0, e}, {32'h0, exp_e});
         chk("rand_rdata", r, exp_r);
         tb_val = $urandom;
         tb_oe  = ~dut_drives();
         idle(2);
         chk("rand_pins", {1'b0, gpio}, {1'b0, pins_exp()});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
